// File: rtl/pid_pkg.sv
// Shared widths and the signed saturate helper for the PID datapath.
package pid_pkg;

  localparam int unsigned W      = 32;
  localparam int unsigned ERR_W  = W + 1;      // setpoint - state
  localparam int unsigned DIFF_W = ERR_W + 1;  // errEff - lastError, integral + errEff
  localparam int unsigned PROD_W = 2 * ERR_W;  // full-precision gain products
  localparam int unsigned SUM_W  = PROD_W + 2; // P + I + D without overflow

  // Upper limit applied first, lower limit second, so lo wins when hi < lo.
  function automatic logic signed [W-1:0] sat_clamp(
    input logic signed [SUM_W-1:0] value,
    input logic signed [W-1:0]     lo,
    input logic signed [W-1:0]     hi
  );
    logic signed [SUM_W-1:0] t;
    t = value;
    if (t > SUM_W'(hi)) t = SUM_W'(hi);
    if (t < SUM_W'(lo)) t = SUM_W'(lo);
    return W'(t);
  endfunction

endpackage

// File: rtl/pid_sat_clamp.sv
// Combinational signed clamp of an IN_W-bit value into [lo, hi] as a W-bit result.
module pid_sat_clamp
  import pid_pkg::*;
#(
  parameter int unsigned IN_W = SUM_W
) (
  input  logic signed [IN_W-1:0] value,
  input  logic signed [W-1:0]    lo,
  input  logic signed [W-1:0]    hi,
  output logic signed [W-1:0]    clamped_c
);

  assign clamped_c = sat_clamp(SUM_W'(value), lo, hi);

endmodule

// File: rtl/pid_controller_unit.sv
// Three-stage fixed-point PID regulator: error/integral, gain products, sum and output clamp.
module pid_controller_unit
  import pid_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic signed [W-1:0] Kp,
  input  logic signed [W-1:0] Ki,
  input  logic signed [W-1:0] Kd,
  input  logic signed [W-1:0] state,
  input  logic signed [W-1:0] setpoint,
  input  logic signed [W-1:0] outputPosMax,
  input  logic signed [W-1:0] outputNegMax,
  input  logic signed [W-1:0] integralPosMax,
  input  logic signed [W-1:0] integralNegMax,
  input  logic        [W-1:0] deadBand,
  input  logic                update_controller,
  output logic signed [W-1:0] result
);

  logic signed [W-1:0]      integral;
  logic signed [ERR_W-1:0]  last_error;

  logic signed [ERR_W-1:0]  err_c;
  logic        [ERR_W-1:0]  err_mag_c;
  logic signed [ERR_W-1:0]  err_eff_c;
  logic signed [DIFF_W-1:0] diff_c;
  logic signed [DIFF_W-1:0] integral_sum_c;
  logic signed [W-1:0]      integral_next_c;

  logic                     s1_valid;
  logic signed [ERR_W-1:0]  s1_err_eff;
  logic signed [DIFF_W-1:0] s1_diff;
  logic signed [W-1:0]      s1_integral;
  logic signed [W-1:0]      s1_kp, s1_ki, s1_kd;
  logic signed [W-1:0]      s1_out_hi, s1_out_lo;

  logic                     s2_valid;
  logic signed [PROD_W-1:0] s2_p, s2_i, s2_d;
  logic signed [W-1:0]      s2_out_hi, s2_out_lo;

  logic signed [SUM_W-1:0]  sum_c;
  logic signed [W-1:0]      result_next_c;

  // Error, deadband and the pre-clamp integral/derivative terms
  always_comb begin
    err_c          = ERR_W'(setpoint) - ERR_W'(state);
    err_mag_c      = err_c[ERR_W-1] ? $unsigned(-err_c) : $unsigned(err_c);
    err_eff_c      = (err_mag_c <= ERR_W'(deadBand)) ? '0 : err_c;
    diff_c         = DIFF_W'(err_eff_c) - DIFF_W'(last_error);
    integral_sum_c = DIFF_W'(integral) + DIFF_W'(err_eff_c);
  end

  pid_sat_clamp #(.IN_W(DIFF_W)) u_integral_clamp (
    .value     (integral_sum_c),
    .lo        (integralNegMax),
    .hi        (integralPosMax),
    .clamped_c (integral_next_c)
  );

  assign sum_c = SUM_W'(s2_p) + SUM_W'(s2_i) + SUM_W'(s2_d);

  pid_sat_clamp #(.IN_W(SUM_W)) u_output_clamp (
    .value     (sum_c),
    .lo        (s2_out_lo),
    .hi        (s2_out_hi),
    .clamped_c (result_next_c)
  );

  // Stage 1: controller state update and operand capture
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      integral    <= '0;
      last_error  <= '0;
      s1_valid    <= 1'b0;
      s1_err_eff  <= '0;
      s1_diff     <= '0;
      s1_integral <= '0;
      s1_kp       <= '0;
      s1_ki       <= '0;
      s1_kd       <= '0;
      s1_out_hi   <= '0;
      s1_out_lo   <= '0;
    end else begin
      s1_valid <= update_controller;
      if (update_controller) begin
        integral    <= integral_next_c;
        last_error  <= err_eff_c;
        s1_err_eff  <= err_eff_c;
        s1_diff     <= diff_c;
        s1_integral <= integral_next_c;
        s1_kp       <= Kp;
        s1_ki       <= Ki;
        s1_kd       <= Kd;
        s1_out_hi   <= outputPosMax;
        s1_out_lo   <= outputNegMax;
      end
    end
  end

  // Stage 2: full-precision products
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s2_valid  <= 1'b0;
      s2_p      <= '0;
      s2_i      <= '0;
      s2_d      <= '0;
      s2_out_hi <= '0;
      s2_out_lo <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_p      <= PROD_W'(s1_kp) * PROD_W'(s1_err_eff);
        s2_i      <= PROD_W'(s1_ki) * PROD_W'(s1_integral);
        s2_d      <= PROD_W'(s1_kd) * PROD_W'(s1_diff);
        s2_out_hi <= s1_out_hi;
        s2_out_lo <= s1_out_lo;
      end
    end
  end

  // Stage 3: saturated output, held between updates
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      result <= '0;
    end else if (s2_valid) begin
      result <= result_next_c;
    end
  end

endmodule

// File: tb/tb_pid_controller_unit.sv
// Randomized and directed checks of pid_controller_unit against a wide-integer PID model.
module tb_pid_controller_unit;

  logic               clock;
  logic               reset;
  logic signed [31:0] Kp, Ki, Kd, state, setpoint;
  logic signed [31:0] outputPosMax, outputNegMax, integralPosMax, integralNegMax;
  logic        [31:0] deadBand;
  logic               update_controller;
  logic signed [31:0] result;

  pid_controller_unit dut (
    .clock             (clock),
    .reset             (reset),
    .Kp                (Kp),
    .Ki                (Ki),
    .Kd                (Kd),
    .state             (state),
    .setpoint          (setpoint),
    .outputPosMax      (outputPosMax),
    .outputNegMax      (outputNegMax),
    .integralPosMax    (integralPosMax),
    .integralNegMax    (integralNegMax),
    .deadBand          (deadBand),
    .update_controller (update_controller),
    .result            (result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          due;
    logic [31:0] val;
  } exp_t;

  exp_t               q[$];
  int                 cyc;
  int                 n_checks;
  int                 n_errors;
  logic [31:0]        m_result;
  logic signed [127:0] m_integral;
  logic signed [127:0] m_last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, $signed(got), $signed(exp));
    end
  endtask

  function automatic logic signed [127:0] clamp128(input logic signed [127:0] v,
                                                   input logic signed [127:0] lo,
                                                   input logic signed [127:0] hi);
    logic signed [127:0] t;
    t = v;
    if (t > hi) t = hi;
    if (t < lo) t = lo;
    return t;
  endfunction

  // Reference: one update evaluated with unbounded-style integer arithmetic
  task automatic model_update();
    logic signed [127:0] e, mag, db, eff, diff, p, i, d, sum;
    logic signed [127:0] sp, st, kp, ki, kd, ilo, ihi, olo, ohi;
    sp = setpoint; st = state; kp = Kp; ki = Ki; kd = Kd;
    ilo = integralNegMax; ihi = integralPosMax; olo = outputNegMax; ohi = outputPosMax;
    db  = {96'd0, deadBand};
    e   = sp - st;
    mag = (e < 0) ? -e : e;
    eff = (mag <= db) ? 128'sd0 : e;
    diff = eff - m_last;
    m_integral = clamp128(m_integral + eff, ilo, ihi);
    m_last = eff;
    p = kp * eff;
    i = ki * m_integral;
    d = kd * diff;
    sum = clamp128(p + i + d, olo, ohi);
    q.push_back('{due: cyc + 3, val: sum[31:0]});
  endtask

  task automatic step();
    @(posedge clock);
    cyc++;
    #1;
    while (q.size() > 0 && q[0].due == cyc) begin
      m_result = q[0].val;
      void'(q.pop_front());
    end
    check("result", result, m_result);
  endtask

  task automatic upd(input logic strobe);
    update_controller = strobe;
    if (strobe) model_update();
    step();
  endtask

  task automatic do_reset();
    update_controller = 1'b0;
    reset = 1'b0;
    #1;
    check("reset_async", result, 32'd0);
    q.delete();
    m_result = '0;
    m_integral = '0;
    m_last = '0;
    @(posedge clock);
    cyc++;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic cfg(input int kp, input int ki, input int kd, input int opos, input int oneg,
                     input int ipos, input int ineg, input int db);
    Kp = kp; Ki = ki; Kd = kd;
    outputPosMax = opos; outputNegMax = oneg;
    integralPosMax = ipos; integralNegMax = ineg;
    deadBand = 32'(db);
  endtask

  function automatic logic signed [31:0] rnd();
    if ($urandom_range(0, 1) == 0) return $urandom;
    return 32'($urandom_range(0, 2000)) - 32'sd1000;
  endfunction

  initial begin
    cyc = 0; n_checks = 0; n_errors = 0;
    m_result = '0; m_integral = '0; m_last = '0;
    update_controller = 1'b0;
    reset = 1'b0;
    cfg(0, 0, 0, 0, 0, 0, 0, 0);
    setpoint = 0; state = 0;
    #3;
    do_reset();

    // Proportional only, then hold
    cfg(2, 0, 0, 1000, -1000, 1000, -1000, 0);
    setpoint = 100; state = 40;
    upd(1); upd(0); upd(0);
    check("p_only", result, 32'd120);
    upd(0); upd(0);
    check("p_hold", result, 32'd120);

    // Deadband suppresses small error
    do_reset();
    cfg(2, 0, 0, 1000, -1000, 1000, -1000, 10);
    setpoint = 105; state = 100;
    upd(1); upd(0); upd(0);
    check("deadband_in", result, 32'd0);
    state = 80;
    upd(1); upd(0); upd(0);
    check("deadband_out", result, 32'd50);

    // Integral accumulation into its clamp, back-to-back
    do_reset();
    cfg(0, 1, 0, 1000, -1000, 25, -25, 0);
    setpoint = 10; state = 0;
    upd(1); upd(1); upd(1);
    check("integ_1", result, 32'd10);
    upd(0);
    check("integ_2", result, 32'd20);
    upd(0);
    check("integ_clamp", result, 32'd25);

    // Derivative, first update uses lastError = 0
    do_reset();
    cfg(0, 0, 3, 1000, -1000, 1000, -1000, 0);
    setpoint = 10; state = 0;
    upd(1); upd(0); upd(0);
    check("deriv_first", result, 32'd30);
    setpoint = 4;
    upd(1); upd(0); upd(0);
    check("deriv_second", result, -32'sd18);

    // Output saturation at both limits
    do_reset();
    cfg(100, 0, 0, 1000, -500, 1000, -1000, 0);
    setpoint = 60; state = 0;
    upd(1); upd(0); upd(0);
    check("sat_pos", result, 32'd1000);
    setpoint = -60;
    upd(1); upd(0); upd(0);
    check("sat_neg", result, -32'sd500);

    // Misconfigured limits: lower limit wins
    cfg(1, 0, 0, -10, 10, 1000, -1000, 0);
    setpoint = 0;
    upd(1); upd(0); upd(0);
    check("sat_misconfig", result, 32'd10);

    // Asynchronous reset with an update in flight
    do_reset();
    cfg(0, 1, 0, 1000, -1000, 1000, -1000, 0);
    setpoint = 10; state = 0;
    upd(1); upd(1); upd(1);
    check("pre_reset", result, 32'd10);
    #2;
    do_reset();
    setpoint = 5;
    upd(1); upd(0); upd(0);
    check("post_reset", result, 32'd5);
    upd(0); upd(0);

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 19) == 0)
        cfg(rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), rnd(),
            ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 50)) : int'($urandom));
      setpoint = rnd();
      state = rnd();
      if ($urandom_range(0, 199) == 0) begin
        #2;
        do_reset();
      end else begin
        upd($urandom_range(0, 9) < 7);
      end
    end
    upd(0); upd(0); upd(0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pid_controller_unit.md
Name: pid_controller_unit

Overview:
- Fixed-point discrete PID regulator for one actuator channel.
- Each update request computes error = setpoint - state, applies a deadband, and accumulates a clamped integral and a derivative term.
- Produces a saturated signed 32-bit control output.
- Sits between the sensor/state path and the motor command path; a higher-level scheduler issues update requests.

Parameters:
- W, 32, data width of all gains, limits, state, setpoint and result (two's complement).

Ports:
- clock  in  1  system clock, rising-edge active
- reset  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- Kp  in  32  signed proportional gain, integer
- Ki  in  32  signed integral gain, integer
- Kd  in  32  signed derivative gain, integer
- state  in  32  signed measured value
- setpoint  in  32  signed target value
- outputPosMax  in  32  signed upper output limit
- outputNegMax  in  32  signed lower output limit (normally negative)
- integralPosMax  in  32  signed upper integral limit
- integralNegMax  in  32  signed lower integral limit
- deadBand  in  32  unsigned error deadband magnitude
- update_controller  in  1  update strobe; each cycle it is high requests one update
- result  out  32  signed control output, registered

Behaviour:
- Reset (reset=0, asynchronous): result=0, integral=0, lastError=0, all pipeline registers and valid flags cleared. A reset mid-pipeline discards in-flight updates. Release is synchronous to clock.
- Three-stage pipeline, fully pipelined: one update per cycle is accepted and back-to-back strobes are legal. All inputs are sampled on edge N when update_controller=1. result changes on edge N+2 and holds otherwise.
- Stage 1 (edge N):
  - err = setpoint - state, 33-bit signed.
  - errEff = 0 if |err| <= deadBand; otherwise errEff = err.
  - diff = errEff - lastError.
  - integral <= clamp(integral + errEff, integralNegMax, integralPosMax).
  - lastError <= errEff.
  - Gains and output limits are registered alongside.
- Stage 2 (edge N+1):
  - P = Kp*errEff, I = Ki*integral (updated value), D = Kd*diff.
  - Full-precision signed products, 66-bit; no truncation.
- Stage 3 (edge N+2): sum = P+I+D at 68 bits; result <= clamp(sum, outputNegMax, outputPosMax).
- Clamp rule: apply the upper limit first, then the lower limit. If limits are misconfigured (Pos < Neg), the lower limit wins.
- When update_controller=0, integral, lastError and result hold; no state change.
- The first update after reset uses lastError=0, so D = Kd*errEff.
- No rounding or fractional scaling: gains are plain integers.

Decomposition:
- Shared package pid_pkg: constant W=32, product/sum width constants, a signed saturate/clamp function.
- One natural sub-module: pid_sat_clamp (signed value, lo, hi -> clamped W-bit). It is instantiated for the integral and for the output.

Test Plan:
- P only: Kp=2, Ki=Kd=0, setpoint=100, state=40, deadBand=0, limits ±1000, one strobe -> result=120 two edges after the strobe edge; result holds 120 with no further strobes.
- Deadband: Kp=2, deadBand=10, setpoint=105, state=100 -> result=0 and the integral is unchanged. With state=80 (err 25) -> result=50.
- Integral and its clamp: Kp=Kd=0, Ki=1, err=10, integralPosMax=25, three back-to-back strobes -> results 10, 20, 25 on consecutive cycles.
- Derivative: Kp=Ki=0, Kd=3. Strobe with err=10 -> 30. Then strobe with err=4 -> -18.
- Output saturation: Kp=100, outputPosMax=1000, outputNegMax=-500.
  - err=60 -> result=1000.
  - err=-60 -> result=-500.
- Reset mid-operation: integral=20 with an update in flight, assert reset=0 -> result=0 immediately (asynchronously). After release, a strobe with Ki=1, err=5 -> result=5.
